// File: rtl/gb_dma_pkg.sv
// rtl/gb_dma_pkg.sv - register addresses, state encodings and constants for hdma_ctrl
// HBlank states exist only when HDMA_HBLANK_EN is defined.
package gb_dma_pkg;

  localparam logic [15:0] ADDR_HDMA1 = 16'hFF51;
  localparam logic [15:0] ADDR_HDMA2 = 16'hFF52;
  localparam logic [15:0] ADDR_HDMA3 = 16'hFF53;
  localparam logic [15:0] ADDR_HDMA4 = 16'hFF54;
  localparam logic [15:0] ADDR_HDMA5 = 16'hFF55;

  localparam int          BLOCK_BYTES   = 16;
  localparam logic [7:0]  IDLE_READBACK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
`ifdef HDMA_HBLANK_EN
    GDMA_RUN  = 2'd1,
    HDMA_WAIT = 2'd2,
    HDMA_RUN  = 2'd3
`else
    GDMA_RUN  = 2'd1
`endif
  } dma_state_t;

  // A length field of n moves n+1 sixteen-byte blocks.
  function automatic logic [11:0] gdma_bytes(input logic [6:0] len);
    logic [7:0] blocks;
    blocks = {1'b0, len} + 8'd1;
    return {blocks, 4'b0000};
  endfunction

endpackage

// File: rtl/hdma_ctrl.sv
// rtl/hdma_ctrl.sv - CGB VRAM DMA register block and transfer sequencer
// Define HDMA_HBLANK_EN to enable per-HBlank block transfers.
module hdma_ctrl
  import gb_dma_pkg::*;
(
  input  logic        clk4_2,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_wr_en,
  output logic [7:0]  cpu_rd_data,
  input  logic        hblank_start,
  input  logic        lcd_on,
  input  logic        GDMA_finished,
  output logic [7:0]  HDMA1,
  output logic [7:0]  HDMA2,
  output logic [7:0]  HDMA3,
  output logic [7:0]  HDMA4,
  output logic [7:0]  HDMA5,
  output logic        DMA_start,
  output logic        cpu_halt
);

  dma_state_t  state;
  logic [6:0]  len;
  logic [7:0]  idle_rb;
  logic [7:0]  ff55_rb;
  logic        ff55_wr;
  logic        regs_open;
  logic [11:0] step;
  logic [15:0] src_next;
  logic [12:0] dst_next;

`ifdef HDMA_HBLANK_EN
  logic [6:0]  remaining;
`else
  logic        unused_hblank;
  assign unused_hblank = hblank_start ^ lcd_on;
`endif

  always_comb begin
    ff55_wr   = cpu_wr_en && (cpu_addr == ADDR_HDMA5);
    regs_open = (state == IDLE);
    step      = gdma_bytes(len);
`ifdef HDMA_HBLANK_EN
    regs_open = (state == IDLE) || (state == HDMA_WAIT);
    if (state == HDMA_RUN) step = 12'(BLOCK_BYTES);
`endif
    // Destination is a 13-bit VRAM offset, so it wraps inside 0x0000-0x1FFF.
    src_next = {HDMA1, HDMA2} + {4'b0000, step};
    dst_next = {HDMA3[4:0], HDMA4} + {1'b0, step};
  end

  always_comb begin
    ff55_rb = idle_rb;
    case (state)
      GDMA_RUN:  ff55_rb = {1'b0, len};
`ifdef HDMA_HBLANK_EN
      HDMA_WAIT: ff55_rb = {1'b0, remaining};
      HDMA_RUN:  ff55_rb = {1'b0, remaining};
`endif
      default:   ff55_rb = idle_rb;
    endcase

    cpu_rd_data = 8'h00;
    case (cpu_addr)
      ADDR_HDMA1, ADDR_HDMA2, ADDR_HDMA3, ADDR_HDMA4: cpu_rd_data = 8'hFF;
      ADDR_HDMA5: cpu_rd_data = ff55_rb;
      default:    cpu_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      HDMA1     <= 8'h00;
      HDMA2     <= 8'h00;
      HDMA3     <= 8'h00;
      HDMA4     <= 8'h00;
      HDMA5     <= 8'h00;
      DMA_start <= 1'b0;
      cpu_halt  <= 1'b0;
      len       <= 7'd0;
      idle_rb   <= IDLE_READBACK;
`ifdef HDMA_HBLANK_EN
      remaining <= 7'd0;
`endif
    end else begin
      DMA_start <= 1'b0;

      if (cpu_wr_en && regs_open) begin
        case (cpu_addr)
          ADDR_HDMA1: HDMA1 <= cpu_wr_data;
          ADDR_HDMA2: HDMA2 <= {cpu_wr_data[7:4], 4'h0};
          ADDR_HDMA3: HDMA3 <= {3'b000, cpu_wr_data[4:0]};
          ADDR_HDMA4: HDMA4 <= {cpu_wr_data[7:4], 4'h0};
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (ff55_wr) begin
`ifdef HDMA_HBLANK_EN
            if (cpu_wr_data[7]) begin
              remaining <= cpu_wr_data[6:0];
              state     <= HDMA_WAIT;
            end else
`endif
            begin
              len       <= cpu_wr_data[6:0];
              HDMA5     <= {1'b0, cpu_wr_data[6:0]};
              DMA_start <= 1'b1;
              cpu_halt  <= 1'b1;
              state     <= GDMA_RUN;
            end
          end
        end

        GDMA_RUN: begin
          if (GDMA_finished) begin
            HDMA1    <= src_next[15:8];
            HDMA2    <= src_next[7:0];
            HDMA3    <= {3'b000, dst_next[12:8]};
            HDMA4    <= dst_next[7:0];
            cpu_halt <= 1'b0;
            idle_rb  <= IDLE_READBACK;
            state    <= IDLE;
          end
        end

`ifdef HDMA_HBLANK_EN
        HDMA_WAIT: begin
          // A cancelling write beats a coincident HBlank pulse.
          if (ff55_wr && !cpu_wr_data[7]) begin
            idle_rb <= {1'b1, remaining};
            state   <= IDLE;
          end else if (hblank_start && lcd_on) begin
            HDMA5     <= 8'h00;
            DMA_start <= 1'b1;
            cpu_halt  <= 1'b1;
            state     <= HDMA_RUN;
          end
        end

        HDMA_RUN: begin
          if (GDMA_finished) begin
            HDMA1    <= src_next[15:8];
            HDMA2    <= src_next[7:0];
            HDMA3    <= {3'b000, dst_next[12:8]};
            HDMA4    <= dst_next[7:0];
            cpu_halt <= 1'b0;
            if (remaining == 7'd0) begin
              idle_rb <= IDLE_READBACK;
              state   <= IDLE;
            end else begin
              remaining <= remaining - 7'd1;
              state     <= HDMA_WAIT;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
